dep_issue_sched: RTL and testbench
==================================

Name: dep_issue_sched

Overview:
- Consumer end of the instruction dependency path. Each instruction allocated into instruction buffer slot `buffer_index` arrives with its dependency vector `idt` from the register tracking table.
- The block stores one dependency row per slot and tracks per-slot state.
- It selects one dependency-free instruction per cycle for issue and clears dependency columns when slots complete.
- Sits between the dependency tracker and the execution units.

Parameters:
- bs, 16, number of instruction buffer slots (rows/columns of the dependency matrix).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- alloc_valid  input  1  allocate an instruction this cycle.
- buffer_index  input  $clog2(bs)  slot being allocated.
- idt  input  bs  dependency vector; bit j=1 means the new instruction depends on slot j.
- issue_valid  output  1  a ready instruction is offered.
- issue_index  output  $clog2(bs)  slot offered.
- issue_ready  input  1  execution unit accepts the offered slot.
- complete_valid  input  1  a slot finished execution.
- complete_index  input  $clog2(bs)  slot finished.
- free_vec  output  bs  bit i=1 means slot i is FREE.
- full  output  1  no FREE slot.
- empty  output  1  all slots FREE.
- err  output  1  sticky protocol error flag.

Behaviour:
- Per-slot state, 2 bits: FREE, WAIT, ISSUED.
- Dependency matrix dep[i][j] is bs x bs flops.
- Reset (async):
  - all slots FREE, dep all 0.
  - Outputs: issue_valid=0, issue_index=0, free_vec=all 1, full=0, empty=1, err=0.
  - A reset mid-operation discards all slots immediately.
- Allocate: alloc_valid with slot FREE:
  - slot -> WAIT.
  - dep[slot] <= idt with bit[slot] forced 0, and with bits of FREE slots forced 0.
  - This also masks the all-ones vector the tracker emits after its own reset.
- Allocate into a non-FREE slot: ignored (state and row unchanged); err set.
- Ready: slot i is ready when state==WAIT and dep[i]==0.
- Selection and issue outputs:
  - issue_valid = OR of ready.
  - issue_index = lowest-index ready slot; 0 when none is ready.
  - Both are combinational from registered state only; they never depend on same-cycle alloc, complete or issue_ready inputs.
- Issue: issue_valid && issue_ready -> the offered slot -> ISSUED at the clock edge.
- Complete: complete_valid with slot ISSUED:
  - slot -> FREE, dep[slot] cleared.
  - Column complete_index cleared in every row.
- Complete for a slot not ISSUED: ignored; err set.
- Latency:
  - An allocated instruction with no live dependencies appears on issue_valid the cycle after alloc.
  - A consumer of a completed slot becomes ready the cycle after complete_valid.
- Simultaneous events, all in one cycle, are legal:
  - alloc + issue + complete.
  - If complete_index equals an idt bit position, the new row captures that bit as 0 (completion bypass).
  - If alloc buffer_index equals complete_index, complete is applied first, the slot is then FREE and alloc succeeds with no err.
  - Issue and complete of the same slot in one cycle is impossible: the slot is WAIT for issue and ISSUED for complete. Complete is ignored and err is set.
- Status outputs:
  - free_vec, full and empty are registered-state derived (combinational from state flops).
  - They reflect updates the cycle after the edge.
- err: sticky until rst.

Optional Feature:
- Macro: OLDEST_FIRST_EN.
- Defined:
  - An age matrix (older[i][j], bs x bs) is maintained.
  - On alloc, row slot is set to the current non-FREE mask and column slot is cleared.
  - issue_index selects the ready slot with no older ready slot.
  - Ties are impossible.
- Undefined: lowest-index ready slot is selected and no age matrix exists.

Test Plan:
- Reset:
  - Assert rst mid-run with 3 slots WAIT.
  - Expected: immediately issue_valid=0, free_vec=16'hFFFF, empty=1, err=0.
- Independent instruction:
  - alloc slot 5, idt=16'hFFFF after reset.
  - Expected: row masked to 0; issue_valid=1, issue_index=5 next cycle; issue_ready=1 -> slot 5 ISSUED, issue_valid=0.
- RAW chain:
  - alloc slot 0 with idt=0, alloc slot 1 with idt=16'h0001, issue slot 0.
  - Slot 1 is not offered.
  - complete_index=0 -> issue_valid=1, issue_index=1 the following cycle.
- Same-cycle bypass:
  - complete slot 2 while allocating slot 3 with idt=16'h0004.
  - Expected: slot 3 offered the next cycle, err=0.
- Full and illegal events:
  - Fill all 16 slots -> full=1.
  - alloc slot 7 again -> err=1, slot 7 row unchanged.
  - complete of a WAIT slot -> ignored, err stays 1.
- Priority:
  - Slots 9 then 4 allocated ready.
  - Expected: offer 4 without OLDEST_FIRST_EN; offer 9 with OLDEST_FIRST_EN.

Source files
------------

// File: rtl/dep_issue_sched.sv
// Purpose: dependency-matrix issue scheduler; holds one dependency row per buffer slot and offers one ready slot per cycle.
// Latency: a dependency-free alloc is offered the cycle after alloc; a consumer wakes the cycle after its producer completes.
// Backpressure: the offer holds while issue_ready is low; illegal alloc/complete events are dropped and set sticky err.
// Optional: define OLDEST_FIRST_EN to select the oldest ready slot via an age matrix instead of the lowest index.
module dep_issue_sched #(
  parameter int bs = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  input  logic [$clog2(bs)-1:0]  buffer_index,
  input  logic [bs-1:0]          idt,
  output logic                   issue_valid,
  output logic [$clog2(bs)-1:0]  issue_index,
  input  logic                   issue_ready,
  input  logic                   complete_valid,
  input  logic [$clog2(bs)-1:0]  complete_index,
  output logic [bs-1:0]          free_vec,
  output logic                   full,
  output logic                   empty,
  output logic                   err
);

  localparam int iw = $clog2(bs);

  typedef enum logic [1:0] {
    S_FREE   = 2'b00,
    S_WAIT   = 2'b01,
    S_ISSUED = 2'b10
  } slot_state_t;

  slot_state_t         state [bs];
  logic [bs-1:0]       dep   [bs];
  logic [bs-1:0]       ready;
  logic [bs-1:0]       live_n;
  logic [bs-1:0]       alloc_row;
  logic                cpl_ok;
  logic                alloc_ok;
  logic                issue_fire;

  // Per-slot readiness and status vectors, purely from registered state.
  always_comb begin
    ready    = '0;
    free_vec = '0;
    for (int i = 0; i < bs; i++) begin
      ready[i]    = (state[i] == S_WAIT) && (dep[i] == '0);
      free_vec[i] = (state[i] == S_FREE);
    end
    full  = ~|free_vec;
    empty = &free_vec;
  end

`ifdef OLDEST_FIRST_EN
  // older[i][j]=1 means slot j was allocated before slot i and is still tracked.
  logic [bs-1:0] older [bs];

  // Offer the ready slot that has no older ready slot; age order is total so it is unique.
  always_comb begin
    issue_valid = |ready;
    issue_index = '0;
    for (int i = 0; i < bs; i++) begin
      if (ready[i] && ((ready & older[i]) == '0)) begin
        issue_index = i[iw-1:0];
      end
    end
  end

  // Age matrix: a new slot is younger than everything live; nobody treats it as older.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) begin
        older[i] <= '0;
      end
    end else if (alloc_ok) begin
      for (int i = 0; i < bs; i++) begin
        older[i][buffer_index] <= 1'b0;
      end
      older[buffer_index] <= live_n;
    end
  end
`else
  // Offer the lowest-index ready slot.
  always_comb begin
    issue_valid = |ready;
    issue_index = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_index = i[iw-1:0];
      end
    end
  end
`endif

  // Event qualification: completion applies first so a same-cycle alloc sees the freed slot and bypassed column.
  always_comb begin
    cpl_ok     = complete_valid && (state[complete_index] == S_ISSUED);
    issue_fire = issue_valid && issue_ready;
    live_n     = ~free_vec;
    if (cpl_ok) begin
      live_n[complete_index] = 1'b0;
    end
    alloc_ok  = alloc_valid && !live_n[buffer_index];
    // Dependencies on free slots (incl. tracker's post-reset all-ones) and on itself are meaningless.
    alloc_row = idt & live_n;
    alloc_row[buffer_index] = 1'b0;
  end

  // Slot state, dependency rows and sticky error update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) begin
        state[i] <= S_FREE;
        dep[i]   <= '0;
      end
      err <= 1'b0;
    end else begin
      if (cpl_ok) begin
        state[complete_index] <= S_FREE;
        for (int i = 0; i < bs; i++) begin
          dep[i][complete_index] <= 1'b0;
        end
        dep[complete_index] <= '0;
      end
      if (issue_fire) begin
        state[issue_index] <= S_ISSUED;
      end
      if (alloc_ok) begin
        state[buffer_index] <= S_WAIT;
        dep[buffer_index]   <= alloc_row;
      end
      if ((alloc_valid && !alloc_ok) || (complete_valid && !cpl_ok)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dep_issue_sched.sv
// Bench for dep_issue_sched: directed scenarios, a slot-level reference model and literal spot checks.
// The model tracks each slot as free/waiting/issued, its pending producers and its allocation order.
// Outputs are compared against the model on every falling edge outside reset.
module tb_dep_issue_sched;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  buffer_index;
  logic [15:0] idt;
  logic        issue_valid;
  logic [3:0]  issue_index;
  logic        issue_ready;
  logic        complete_valid;
  logic [3:0]  complete_index;
  logic [15:0] free_vec;
  logic        full;
  logic        empty;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: 0 = free, 1 = waiting, 2 = issued.
  int          ms    [16];
  logic [15:0] md    [16];
  int          mseq  [16];
  int          seqc;
  bit          merr;

  dep_issue_sched #(.bs(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .buffer_index   (buffer_index),
    .idt            (idt),
    .issue_valid    (issue_valid),
    .issue_index    (issue_index),
    .issue_ready    (issue_ready),
    .complete_valid (complete_valid),
    .complete_index (complete_index),
    .free_vec       (free_vec),
    .full           (full),
    .empty          (empty),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Which slot must be offered: among waiting slots with no pending producer,
  // the lowest index, or the earliest allocated when oldest-first is built in.
  function automatic void pick(output bit v, output int idx);
    v   = 1'b0;
    idx = 0;
    for (int k = 0; k < 16; k++) begin
      if (ms[k] == 1 && md[k] == 16'h0) begin
`ifdef OLDEST_FIRST_EN
        if (!v || mseq[k] < mseq[idx]) begin
          v = 1'b1;
          idx = k;
        end
`else
        if (!v) begin
          v = 1'b1;
          idx = k;
        end
`endif
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    bit ov;
    int oi;
    int ci;
    int bi;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        ms[k] = 0;
        md[k] = 16'h0;
        mseq[k] = 0;
      end
      merr = 1'b0;
      seqc = 0;
    end else begin
      pick(ov, oi);
      ci = int'(complete_index);
      bi = int'(buffer_index);
      if (complete_valid) begin
        if (ms[ci] == 2) begin
          ms[ci] = 0;
          md[ci] = 16'h0;
          for (int k = 0; k < 16; k++) md[k][ci] = 1'b0;
        end else begin
          merr = 1'b1;
        end
      end
      if (ov && issue_ready) ms[oi] = 2;
      if (alloc_valid) begin
        if (ms[bi] == 0) begin
          ms[bi] = 1;
          md[bi] = 16'h0;
          for (int j = 0; j < 16; j++)
            if (idt[j] && j != bi && ms[j] != 0) md[bi][j] = 1'b1;
          mseq[bi] = seqc;
          seqc++;
        end else begin
          merr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit          ev;
    int          ei;
    logic [15:0] ef;
    if (!rst) begin
      pick(ev, ei);
      for (int k = 0; k < 16; k++) ef[k] = (ms[k] == 0);
      chk("issue_valid", 32'(issue_valid), 32'(ev));
      chk("issue_index", 32'(issue_index), ei);
      chk("free_vec", 32'(free_vec), 32'(ef));
      chk("full", 32'(full), 32'(ef == 16'h0));
      chk("empty", 32'(empty), 32'(ef == 16'hFFFF));
      chk("err", 32'(err), 32'(merr));
    end
  end

  // Drive one cycle of inputs from a falling edge; returns at the next falling edge.
  task automatic cyc(input logic av, input int bi, input logic [15:0] dv,
                     input logic ir, input logic cv, input int ci);
    alloc_valid    = av;
    buffer_index   = bi[3:0];
    idt            = dv;
    issue_ready    = ir;
    complete_valid = cv;
    complete_index = ci[3:0];
    @(negedge clk);
    alloc_valid    = 1'b0;
    issue_ready    = 1'b0;
    complete_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0;
    buffer_index = 4'd0;
    idt = 16'h0;
    issue_ready = 1'b0;
    complete_valid = 1'b0;
    complete_index = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_issue_index", 32'(issue_index), 32'd0);
    chk("rst_free_vec", 32'(free_vec), 32'hFFFF);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Independent instruction; all-ones vector is masked to nothing.
    cyc(1, 5, 16'hFFFF, 0, 0, 0);
    chk("ind_valid", 32'(issue_valid), 32'd1);
    chk("ind_index", 32'(issue_index), 32'd5);
    cyc(0, 0, 16'h0, 1, 0, 0);
    chk("ind_issued_valid", 32'(issue_valid), 32'd0);
    cyc(0, 0, 16'h0, 0, 1, 5);
    chk("ind_empty", 32'(empty), 32'd1);

    // RAW chain 0 -> 1.
    cyc(1, 0, 16'h0000, 0, 0, 0);
    cyc(1, 1, 16'h0001, 0, 0, 0);
    chk("raw_first", 32'(issue_index), 32'd0);
    cyc(0, 0, 16'h0, 1, 0, 0);
    chk("raw_blocked", 32'(issue_valid), 32'd0);
    cyc(0, 0, 16'h0, 0, 1, 0);
    chk("raw_wake_valid", 32'(issue_valid), 32'd1);
    chk("raw_wake_index", 32'(issue_index), 32'd1);
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(0, 0, 16'h0, 0, 1, 1);

    // Completion bypass into a same-cycle alloc.
    cyc(1, 2, 16'h0000, 0, 0, 0);
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(1, 3, 16'h0004, 0, 1, 2);
    chk("byp_valid", 32'(issue_valid), 32'd1);
    chk("byp_index", 32'(issue_index), 32'd3);
    chk("byp_err", 32'(err), 32'd0);
    cyc(0, 0, 16'h0, 1, 0, 0);
    // Alloc into the slot being completed in the same cycle.
    cyc(1, 3, 16'h0000, 0, 1, 3);
    chk("reuse_err", 32'(err), 32'd0);
    chk("reuse_index", 32'(issue_index), 32'd3);
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(0, 0, 16'h0, 0, 1, 3);

    // Alloc + issue + complete in one cycle; slot 10 depends on 6 (bypassed) and 8 (live).
    cyc(1, 6, 16'h0000, 0, 0, 0);
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(1, 8, 16'h0000, 0, 0, 0);
    cyc(1, 10, 16'h0140, 1, 1, 6);
    chk("tri_wait", 32'(issue_valid), 32'd0);
    cyc(0, 0, 16'h0, 0, 1, 8);
    chk("tri_wake", 32'(issue_index), 32'd10);
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(0, 0, 16'h0, 0, 1, 10);

    // Priority between slots 9 (older) and 4.
    cyc(1, 9, 16'h0000, 0, 0, 0);
    cyc(1, 4, 16'h0000, 0, 0, 0);
`ifdef OLDEST_FIRST_EN
    chk("prio_index", 32'(issue_index), 32'd9);
`else
    chk("prio_index", 32'(issue_index), 32'd4);
`endif
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(0, 0, 16'h0, 0, 1, 4);
    cyc(0, 0, 16'h0, 0, 1, 9);

    // Fill every slot, then illegal events.
    for (int s = 0; s < 16; s++) cyc(1, s, 16'h0000, 0, 0, 0);
    chk("full_set", 32'(full), 32'd1);
    cyc(1, 7, 16'hFFFF, 0, 0, 0);
    chk("dup_alloc_err", 32'(err), 32'd1);
    cyc(0, 0, 16'h0, 0, 1, 3);
    chk("cpl_wait_err", 32'(err), 32'd1);
    chk("cpl_wait_full", 32'(full), 32'd1);

    // Asynchronous reset in mid-cycle with slots still waiting.
    #2 rst = 1'b1;
    #1;
    chk("arst_issue_valid", 32'(issue_valid), 32'd0);
    chk("arst_free_vec", 32'(free_vec), 32'hFFFF);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 12, 16'hFFFF, 0, 0, 0);
    chk("post_rst_index", 32'(issue_index), 32'd12);
    cyc(0, 0, 16'h0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
